// File: rtl/data_mem_ctrl.sv
// -----------------------------------------------------------------------------
// data_mem_ctrl
//
// Word-addressed synchronous data RAM behind a valid/ready request port.
// Replaces the combinational-read data memory of the single-cycle core: the
// load/store path now issues a request and receives exactly one response
// RD_LAT cycles later, in order, with no back-pressure on the response side.
//
// After reset (and on a clr_start pulse while idle) a hardware clear sequence
// walks every word and writes zero. Requests are refused while it runs.
// Addresses at or above DEPTH never touch the array and are flagged with
// rsp_err; there is no aliasing or wrap.
//
// Parameters
//   DATA_W  data word width in bits (multiple of 8)
//   ADDR_W  request address width; the address is a word index
//   DEPTH   number of words (at most 2**ADDR_W)
//   RD_LAT  request-to-response latency in cycles (1..4)
//   BE_W    number of byte lanes, DATA_W/8 (derived, leave at default)
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   req_valid  request present
//   req_ready  request can be accepted this cycle (idle, not clearing)
//   req_we     1 = write, 0 = read
//   req_addr   word index
//   req_wdata  write data
//   req_be     byte-lane write enables, bit k gates bits 8k+7:8k
//   clr_start  one-cycle pulse requesting a full clear (ignored while clearing)
//   rsp_valid  one-cycle response strobe
//   rsp_rdata  read data; 0 for writes, errors and when rsp_valid is low
//   rsp_err    the request address was >= DEPTH
//   init_busy  clear sequence in progress
// -----------------------------------------------------------------------------
module data_mem_ctrl #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 128,
  parameter int RD_LAT = 1,
  parameter int BE_W   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  input  logic              clr_start,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              init_busy
);

  // Width of an in-range word index and of the clear counter.
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  // DEPTH widened by one bit so the range compare is exact even when
  // DEPTH == 2**ADDR_W (every address is then in range).
  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  typedef enum logic {
    ST_INIT,
    ST_IDLE
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] clr_cnt;

  logic             accept;
  logic             in_range;
  logic [IDX_W-1:0] idx;
  logic [DATA_W-1:0] rd_word;

  // Storage array.
  logic [DATA_W-1:0] mem [DEPTH];

  // Response pipeline; the last stage drives the outputs directly so every
  // response output is a flop.
  logic              pipe_valid [RD_LAT];
  logic [DATA_W-1:0] pipe_rdata [RD_LAT];
  logic              pipe_err   [RD_LAT];

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  // req_ready is high only in IDLE, so an accepted request can never collide
  // with a clear-sequence write in the same cycle.
  assign accept   = req_valid & req_ready;
  assign in_range = {1'b0, req_addr} < DEPTH_EXT;
  assign idx      = req_addr[IDX_W-1:0];

  // Read word captured at the acceptance edge. Writes, out-of-range requests
  // and idle cycles all load zero into the first pipeline stage.
  // NOTE: every variable assigned in always_comb gets a default first so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    rd_word = '0;
    if (accept && !req_we && in_range) begin
      rd_word = mem[idx];
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM: clear sequence and request gating
  // ---------------------------------------------------------------------------
  // INIT visits words 0..DEPTH-1, one per cycle, and moves to IDLE on the edge
  // that writes the last word, so the clear takes exactly DEPTH cycles.
  // clr_start is only looked at in IDLE; a request accepted in the same cycle
  // still completes because req_ready was already high for that edge.
  // NOTE: state is updated with non-blocking assignments so every flop sees
  // the pre-edge values of its peers, whatever the statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_INIT;
      clr_cnt   <= '0;
      req_ready <= 1'b0;
      init_busy <= 1'b1;
    end else begin
      case (state)
        ST_INIT: begin
          if (clr_cnt == LAST_IDX) begin
            state     <= ST_IDLE;
            clr_cnt   <= '0;
            req_ready <= 1'b1;
            init_busy <= 1'b0;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        ST_IDLE: begin
          if (clr_start) begin
            state     <= ST_INIT;
            clr_cnt   <= '0;
            req_ready <= 1'b0;
            init_busy <= 1'b1;
          end
        end
        default: begin
          state     <= ST_INIT;
          clr_cnt   <= '0;
          req_ready <= 1'b0;
          init_busy <= 1'b1;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  // NOTE: the array has no reset; it maps onto plain RAM, and the INIT sequence
  // that follows every reset zeroes it before any request can be accepted.
  always_ff @(posedge clk) begin
    if (state == ST_INIT) begin
      mem[clr_cnt] <= '0;
    end else if (accept && req_we && in_range) begin
      for (int k = 0; k < BE_W; k++) begin
        if (req_be[k]) begin
          mem[idx][8*k +: 8] <= req_wdata[8*k +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Response pipeline
  // ---------------------------------------------------------------------------
  // Stage 0 is loaded at the acceptance edge, so the response appears RD_LAT
  // cycles after acceptance. Empty slots carry zero data and zero error, which
  // keeps rsp_rdata/rsp_err at 0 whenever rsp_valid is low. The pipeline keeps
  // shifting during INIT so in-flight responses drain; reset discards them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_valid[i] <= 1'b0;
        pipe_rdata[i] <= '0;
        pipe_err[i]   <= 1'b0;
      end
    end else begin
      pipe_valid[0] <= accept;
      pipe_rdata[0] <= rd_word;
      pipe_err[0]   <= accept & ~in_range;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_rdata[i] <= pipe_rdata[i-1];
        pipe_err[i]   <= pipe_err[i-1];
      end
    end
  end

  assign rsp_valid = pipe_valid[RD_LAT-1];
  assign rsp_rdata = pipe_rdata[RD_LAT-1];
  assign rsp_err   = pipe_err[RD_LAT-1];

endmodule

// File: tb/tb_data_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_data_mem_ctrl
//
// Two controllers share one request stream: u_dut_l1 (RD_LAT=1) and
// u_dut_l3 (RD_LAT=3), each with its own reset. A behavioural model per
// instance holds the memory as a plain array, counts the cycles left in the
// clear sequence and keeps a queue of expected responses tagged with the
// clock edge after which each must be visible. Every cycle, on the falling
// edge, all outputs of both instances are compared against the model.
// -----------------------------------------------------------------------------
module tb_data_mem_ctrl;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;
  localparam int DEPTH  = 128;
  localparam int BE_W   = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]        rst_n_v;
  logic              req_valid;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [BE_W-1:0]   req_be;
  logic              clr_start;

  logic [1:0]        ready_v;
  logic [1:0]        valid_v;
  logic [1:0]        err_v;
  logic [1:0]        busy_v;
  logic [DATA_W-1:0] rdata_l1;
  logic [DATA_W-1:0] rdata_l3;

  data_mem_ctrl #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .RD_LAT(1)
  ) u_dut_l1 (
    .clk      (clk),
    .rst_n    (rst_n_v[0]),
    .req_valid(req_valid),
    .req_ready(ready_v[0]),
    .req_we   (req_we),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .req_be   (req_be),
    .clr_start(clr_start),
    .rsp_valid(valid_v[0]),
    .rsp_rdata(rdata_l1),
    .rsp_err  (err_v[0]),
    .init_busy(busy_v[0])
  );

  data_mem_ctrl #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .RD_LAT(3)
  ) u_dut_l3 (
    .clk      (clk),
    .rst_n    (rst_n_v[1]),
    .req_valid(req_valid),
    .req_ready(ready_v[1]),
    .req_we   (req_we),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .req_be   (req_be),
    .clr_start(clr_start),
    .rsp_valid(valid_v[1]),
    .rsp_rdata(rdata_l3),
    .rsp_err  (err_v[1]),
    .init_busy(busy_v[1])
  );

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  typedef struct {
    int                due;   // edge count after which the response is visible
    logic [DATA_W-1:0] data;
    logic              err;
  } rsp_t;

  rsp_t              q_l1[$];
  rsp_t              q_l3[$];
  logic [DATA_W-1:0] m_mem [2][DEPTH];
  int                m_init_left [2];   // edges still needed before ready
  int                edge_n = 0;
  int                checks = 0;
  int                errors = 0;

  function automatic int lat(int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic void clear_model(int d);
    for (int i = 0; i < DEPTH; i++) m_mem[d][i] = '0;
  endfunction

  task automatic check(string tag, int d, logic [31:0] obs, logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s dut_l%0d edge %0d observed=%0h expected=%0h",
             tag, lat(d), edge_n, obs, expv);
    end
  endtask

  // Effect of the coming rising edge on instance d, from the current inputs.
  task automatic model_edge(int d);
    rsp_t              r;
    int                a;
    logic              ready;
    logic [DATA_W-1:0] mask;
    if (!rst_n_v[d]) return;
    ready = (m_init_left[d] == 0);
    if (ready && req_valid) begin
      a      = int'(req_addr);
      r.due  = edge_n + lat(d);
      r.err  = (a >= DEPTH);
      r.data = '0;
      if (!r.err) begin
        if (req_we) begin
          mask = {{8{req_be[1]}}, {8{req_be[0]}}};
          m_mem[d][a] = (m_mem[d][a] & ~mask) | (req_wdata & mask);
        end else begin
          r.data = m_mem[d][a];
        end
      end
      if (d == 0) q_l1.push_back(r);
      else        q_l3.push_back(r);
    end
    if (!ready) begin
      m_init_left[d]--;
    end else if (clr_start) begin
      // Contents become all-zero before the next request can be accepted.
      m_init_left[d] = DEPTH;
      clear_model(d);
    end
  endtask

  task automatic check_all();
    for (int d = 0; d < 2; d++) begin
      rsp_t              r;
      logic              exp_v;
      logic [DATA_W-1:0] exp_d;
      logic              exp_e;
      logic              rdy;
      logic [DATA_W-1:0] obs_d;
      exp_v = 1'b0;
      exp_d = '0;
      exp_e = 1'b0;
      if (d == 0) begin
        if (q_l1.size() > 0 && q_l1[0].due == edge_n) begin
          r = q_l1.pop_front();
          exp_v = 1'b1; exp_d = r.data; exp_e = r.err;
        end
      end else begin
        if (q_l3.size() > 0 && q_l3[0].due == edge_n) begin
          r = q_l3.pop_front();
          exp_v = 1'b1; exp_d = r.data; exp_e = r.err;
        end
      end
      rdy   = rst_n_v[d] && (m_init_left[d] == 0);
      obs_d = (d == 0) ? rdata_l1 : rdata_l3;
      check("req_ready", d, 32'(ready_v[d]), 32'(rdy));
      check("init_busy", d, 32'(busy_v[d]),  32'(!rdy));
      check("rsp_valid", d, 32'(valid_v[d]), 32'(exp_v));
      check("rsp_rdata", d, 32'(obs_d),      32'(exp_d));
      check("rsp_err",   d, 32'(err_v[d]),   32'(exp_e));
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus helpers (inputs change on the falling edge)
  // ---------------------------------------------------------------------------
  task automatic tick();
    model_edge(0);
    model_edge(1);
    @(posedge clk);
    edge_n++;
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(int n);
    req_valid = 1'b0;
    clr_start = 1'b0;
    repeat (n) tick();
  endtask

  task automatic do_req(logic we, int addr, logic [DATA_W-1:0] wd, logic [BE_W-1:0] be);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = ADDR_W'(addr);
    req_wdata = wd;
    req_be    = be;
    tick();
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_be    = '0;
  endtask

  task automatic set_rst(int d, logic v);
    rst_n_v[d] = v;
    if (!v) begin
      m_init_left[d] = DEPTH;
      clear_model(d);
      if (d == 0) q_l1.delete();
      else        q_l3.delete();
    end
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence followed by random traffic
  // ---------------------------------------------------------------------------
  initial begin
    rst_n_v   = 2'b00;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_be    = '0;
    clr_start = 1'b0;
    for (int d = 0; d < 2; d++) begin
      m_init_left[d] = DEPTH;
      clear_model(d);
    end

    // Reset values, then the full clear sequence after release.
    idle(3);
    set_rst(0, 1'b1);
    set_rst(1, 1'b1);
    idle(DEPTH);
    do_req(1'b0, 0,   '0, '0);
    do_req(1'b0, 64,  '0, '0);
    do_req(1'b0, 127, '0, '0);
    idle(4);

    // Write then read-after-write on the very next cycle.
    do_req(1'b1, 5, 16'hBEEF, 2'b11);
    do_req(1'b0, 5, '0, '0);
    idle(4);

    // Byte lanes, including an all-lanes-off write.
    do_req(1'b1, 9, 16'h1234, 2'b11);
    do_req(1'b1, 9, 16'hAB00, 2'b10);
    do_req(1'b0, 9, '0, '0);
    do_req(1'b1, 9, 16'hFFFF, 2'b00);
    do_req(1'b0, 9, '0, '0);
    do_req(1'b1, 9, 16'h00CD, 2'b01);
    do_req(1'b0, 9, '0, '0);
    idle(4);

    // Out of range: first address past the end and the top of the address space.
    do_req(1'b1, 128,   16'h5555, 2'b11);
    do_req(1'b0, 128,   '0, '0);
    do_req(1'b1, 65535, 16'h5555, 2'b11);
    do_req(1'b0, 0,     '0, '0);
    idle(4);

    // Streaming reads, back to back.
    do_req(1'b1, 1, 16'h0011, 2'b11);
    do_req(1'b1, 2, 16'h0022, 2'b11);
    do_req(1'b1, 3, 16'h0033, 2'b11);
    do_req(1'b0, 1, '0, '0);
    do_req(1'b0, 2, '0, '0);
    do_req(1'b0, 3, '0, '0);
    idle(5);

    // Reset of the RD_LAT=3 instance with two reads in flight.
    do_req(1'b0, 1, '0, '0);
    do_req(1'b0, 2, '0, '0);
    set_rst(1, 1'b0);
    do_req(1'b0, 3, '0, '0);
    idle(4);
    set_rst(1, 1'b1);
    idle(DEPTH + 2);

    // Clear requested together with a write; responses drain during INIT.
    do_req(1'b0, 1, '0, '0);
    clr_start = 1'b1;
    do_req(1'b1, 10, 16'h7777, 2'b11);
    clr_start = 1'b0;
    idle(DEPTH + 2);
    do_req(1'b0, 10, '0, '0);
    do_req(1'b0, 5,  '0, '0);
    idle(4);

    // Reset in the middle of a clear restarts it from the beginning.
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    idle(40);
    set_rst(0, 1'b0);
    set_rst(1, 1'b0);
    idle(2);
    set_rst(0, 1'b1);
    set_rst(1, 1'b1);
    idle(DEPTH + 2);

    // Random traffic, concentrated on a few words so reads hit written data.
    for (int i = 0; i < 600; i++) begin
      int sel;
      sel       = int'($urandom_range(0, 99));
      req_valid = ($urandom_range(0, 9) < 7);
      req_we    = 1'($urandom_range(0, 1));
      if (sel < 70)      req_addr = ADDR_W'($urandom_range(0, 15));
      else if (sel < 88) req_addr = ADDR_W'($urandom_range(0, DEPTH - 1));
      else               req_addr = ADDR_W'($urandom_range(DEPTH, 65535));
      req_wdata = DATA_W'($urandom);
      req_be    = BE_W'($urandom);
      clr_start = ($urandom_range(0, 299) == 0);
      tick();
    end
    idle(DEPTH + 4);
    for (int a = 0; a < 16; a++) do_req(1'b0, a, '0, '0);
    idle(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
